// File: rtl/seq_detect_ctrl_pkg.sv
// Shared definitions for the serial sequence detector controller: state encoding,
// default sizes and the pattern-length clamp. Optional macro: SEQ_DET_NOOVERLAP_EN.
package seq_detect_ctrl_pkg;

    localparam int PAT_W_DEF = 5;
    localparam int CNT_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Lengths of 0 or beyond the history depth fall back to the full depth.
    function automatic int clamp_len(input int len, input int max_len);
        return (len < 1 || len > max_len) ? max_len : len;
    endfunction

endpackage

// File: rtl/seq_detect_ctrl_match_core.sv
// History shift register, fill counter and length-masked comparator.
// SEQ_DET_NOOVERLAP_EN: clear history on a hit so matches never share bits.
module seq_match_core
    import seq_detect_ctrl_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clr,
    input  logic                       shift,
    input  logic                       in,
    input  logic [PAT_W-1:0]           pattern,
    input  logic [$clog2(PAT_W+1)-1:0] len,
    output logic                       hit
);

    localparam int LEN_W = $clog2(PAT_W+1);

    logic [PAT_W-1:0] hist, hist_nxt, mask;
    logic [LEN_W-1:0] fill, fill_nxt;

    always_comb begin
        hist_nxt = {hist[PAT_W-2:0], in};
        fill_nxt = (fill == LEN_W'(PAT_W)) ? fill : fill + 1'b1;
        mask     = '0;
        for (int i = 0; i < PAT_W; i++) begin
            mask[i] = (i < int'(len));
        end
        // fill_nxt counts the incoming bit, so a hit is possible on the len-th bit
        hit = shift && (fill_nxt >= len) && (((hist_nxt ^ pattern) & mask) == '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist <= '0;
            fill <= '0;
        end else if (clr) begin
            hist <= '0;
            fill <= '0;
        end else if (shift) begin
`ifdef SEQ_DET_NOOVERLAP_EN
            if (hit) begin
                hist <= '0;
                fill <= '0;
            end else begin
                hist <= hist_nxt;
                fill <= fill_nxt;
            end
`else
            hist <= hist_nxt;
            fill <= fill_nxt;
`endif
        end
    end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Configuration/sequencing controller around a programmable serial sequence detector.
// Detection mode follows SEQ_DET_NOOVERLAP_EN (see seq_match_core).
//   state | meaning
//   IDLE  | no valid arming; waits for a cfg handshake, start ignored
//   ARMED | config latched; start launches detection
//   RUN   | detecting on in_valid bits; cfg not accepted
//   DONE  | target reached; start reruns, cfg re-arms
module seq_detect_ctrl
    import seq_detect_ctrl_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       cfg_valid,
    output logic                       cfg_ready,
    input  logic [PAT_W-1:0]           cfg_pattern,
    input  logic [$clog2(PAT_W+1)-1:0] cfg_len,
    input  logic [CNT_W-1:0]           cfg_target,
    input  logic                       start,
    input  logic                       abort,
    input  logic                       in_valid,
    input  logic                       in,
    output logic                       match,
    output logic [CNT_W-1:0]           match_cnt,
    output logic                       busy,
    output logic                       done
);

    localparam int LEN_W = $clog2(PAT_W+1);

    state_t           state;
    logic [PAT_W-1:0] pat_q;
    logic [LEN_W-1:0] len_q, len_clamped;
    logic [CNT_W-1:0] tgt_q, cnt_inc;
    logic             cfg_hs, run_go, shift, hit;

    always_comb begin
        cfg_hs      = cfg_valid && cfg_ready;
        run_go      = !abort && !cfg_hs && start && (state == ST_ARMED || state == ST_DONE);
        shift       = !abort && (state == ST_RUN) && in_valid;
        len_clamped = LEN_W'(clamp_len(int'(cfg_len), PAT_W));
        cnt_inc     = (match_cnt == '1) ? match_cnt : match_cnt + 1'b1;
    end

    seq_match_core #(.PAT_W(PAT_W)) u_core (
        .clk     (clk),
        .reset   (reset),
        .clr     (run_go),
        .shift   (shift),
        .in      (in),
        .pattern (pat_q),
        .len     (len_q),
        .hit     (hit)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            pat_q     <= '0;
            len_q     <= LEN_W'(1);
            tgt_q     <= '0;
            match     <= 1'b0;
            match_cnt <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cfg_ready <= 1'b1;
        end else begin
            match <= 1'b0;
            if (abort) begin
                state     <= ST_IDLE;
                busy      <= 1'b0;
                done      <= 1'b0;
                cfg_ready <= 1'b1;
            end else begin
                if (cfg_hs) begin
                    pat_q <= cfg_pattern;
                    len_q <= len_clamped;
                    tgt_q <= cfg_target;
                end
                case (state)
                    ST_IDLE: begin
                        if (cfg_hs) state <= ST_ARMED;
                    end
                    ST_ARMED, ST_DONE: begin
                        if (cfg_hs) begin
                            state <= ST_ARMED;
                            done  <= 1'b0;
                        end else if (start) begin
                            state     <= ST_RUN;
                            match_cnt <= '0;
                            busy      <= 1'b1;
                            done      <= 1'b0;
                            cfg_ready <= 1'b0;
                        end
                    end
                    ST_RUN: begin
                        if (hit) begin
                            match     <= 1'b1;
                            match_cnt <= cnt_inc;
                            // done rises together with the final match pulse
                            if (tgt_q != '0 && cnt_inc == tgt_q) begin
                                state     <= ST_DONE;
                                busy      <= 1'b0;
                                done      <= 1'b1;
                                cfg_ready <= 1'b1;
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Self-checking bench for seq_detect_ctrl: vector table, directed corner sequences
// and randomized traffic against a bit-queue reference model.
module tb_seq_detect_ctrl;

    localparam int PAT_W = 5;
    localparam int CNT_W = 8;
    localparam int LEN_W = $clog2(PAT_W+1);

    logic             clk = 1'b0;
    logic             reset;
    logic             cfg_valid, cfg_ready;
    logic [PAT_W-1:0] cfg_pattern;
    logic [LEN_W-1:0] cfg_len;
    logic [CNT_W-1:0] cfg_target;
    logic             start, abort, in_valid, in;
    logic             match, busy, done;
    logic [CNT_W-1:0] match_cnt;

    seq_detect_ctrl #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_target  (cfg_target),
        .start       (start),
        .abort       (abort),
        .in_valid    (in_valid),
        .in          (in),
        .match       (match),
        .match_cnt   (match_cnt),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: plain flags plus a queue of received bits
    bit               m_run, m_done, m_armed, m_match;
    int               m_cnt, m_len, m_tgt;
    logic [PAT_W-1:0] m_pat;
    int               q[$];

    task automatic model_reset();
        m_run = 0; m_done = 0; m_armed = 0; m_match = 0;
        m_cnt = 0; m_len = 1; m_tgt = 0; m_pat = '0;
        q.delete();
    endtask

    task automatic model_step();
        bit rdy, hit;
        int n;
        rdy     = !m_run;
        m_match = 0;
        if (abort) begin
            m_run = 0; m_done = 0; m_armed = 0;
        end else if (cfg_valid && rdy) begin
            m_pat   = cfg_pattern;
            m_len   = (int'(cfg_len) == 0 || int'(cfg_len) > PAT_W) ? PAT_W : int'(cfg_len);
            m_tgt   = int'(cfg_target);
            m_armed = 1;
            m_done  = 0;
        end else if (start && (m_armed || m_done)) begin
            m_run = 1; m_armed = 0; m_done = 0; m_cnt = 0;
            q.delete();
        end else if (m_run && in_valid) begin
            q.push_back(int'(in));
            if (q.size() > PAT_W) void'(q.pop_front());
            n = q.size();
            if (n >= m_len) begin
                hit = 1;
                for (int k = 0; k < m_len; k++)
                    if (q[n - m_len + k] != int'(m_pat[m_len - 1 - k])) hit = 0;
                if (hit) begin
                    m_match = 1;
                    if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
`ifdef SEQ_DET_NOOVERLAP_EN
                    q.delete();
`endif
                    if (m_tgt != 0 && m_cnt == m_tgt) begin
                        m_run = 0; m_done = 1;
                    end
                end
            end
        end
    endtask

    task automatic drive(input logic cv, input logic [PAT_W-1:0] p, input logic [LEN_W-1:0] l,
                         input logic [CNT_W-1:0] t, input logic st, input logic ab,
                         input logic iv, input logic b);
        cfg_valid = cv; cfg_pattern = p; cfg_len = l; cfg_target = t;
        start = st; abort = ab; in_valid = iv; in = b;
    endtask

    task automatic idle();
        drive(0, '0, '0, '0, 0, 0, 0, 0);
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_step();
        #1;
        check({tag, ".match"},     32'(match),     32'(m_match));
        check({tag, ".match_cnt"}, 32'(match_cnt), 32'(m_cnt));
        check({tag, ".busy"},      32'(busy),      32'(m_run));
        check({tag, ".done"},      32'(done),      32'(m_done));
        check({tag, ".cfg_ready"}, 32'(cfg_ready), 32'(!m_run));
    endtask

    task automatic send_bit(input logic b, input string tag);
        drive(0, '0, '0, '0, 0, 0, 1, b);
        tick(tag);
    endtask

    typedef struct {
        logic cv; logic [PAT_W-1:0] pat; logic [LEN_W-1:0] len; logic [CNT_W-1:0] tgt;
        logic st; logic ab; logic iv; logic b;
        logic em; logic [CNT_W-1:0] ecnt; logic eb; logic ed; logic er;
    } vec_t;

    vec_t tbl[9];

    initial begin
        int pulses, gap_pulses, first_hit;
        logic [6:0] ov_bits;
        logic [6:0] ts_bits;

        tbl[0] = '{1, 5'b00001, 3'd1, 8'd0, 0, 0, 0, 0,  0, 8'd0, 0, 0, 1};
        tbl[1] = '{0, 5'b00000, 3'd0, 8'd0, 1, 0, 0, 0,  0, 8'd0, 1, 0, 0};
        tbl[2] = '{0, 5'b00000, 3'd0, 8'd0, 0, 0, 1, 0,  0, 8'd0, 1, 0, 0};
        tbl[3] = '{0, 5'b00000, 3'd0, 8'd0, 0, 0, 1, 1,  1, 8'd1, 1, 0, 0};
        tbl[4] = '{0, 5'b00000, 3'd0, 8'd0, 0, 0, 1, 1,  1, 8'd2, 1, 0, 0};
        tbl[5] = '{0, 5'b00000, 3'd0, 8'd0, 0, 0, 1, 0,  0, 8'd2, 1, 0, 0};
        tbl[6] = '{0, 5'b00000, 3'd0, 8'd0, 0, 0, 0, 1,  0, 8'd2, 1, 0, 0};
        tbl[7] = '{0, 5'b00000, 3'd0, 8'd0, 0, 1, 0, 0,  0, 8'd2, 0, 0, 1};
        tbl[8] = '{0, 5'b00000, 3'd0, 8'd0, 1, 0, 0, 0,  0, 8'd2, 0, 0, 1};

        idle();
        reset = 1'b0;
        #2 reset = 1'b1;
        #1;
        model_reset();
        check("rst.match",     32'(match),     32'd0);
        check("rst.match_cnt", 32'(match_cnt), 32'd0);
        check("rst.busy",      32'(busy),      32'd0);
        check("rst.done",      32'(done),      32'd0);
        check("rst.cfg_ready", 32'(cfg_ready), 32'd1);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // start from IDLE before any config is ignored
        drive(0, '0, '0, '0, 1, 0, 0, 0);
        tick("idle_start");
        check("idle_start.busy", 32'(busy), 32'd0);

        for (int i = 0; i < 9; i++) begin
            drive(tbl[i].cv, tbl[i].pat, tbl[i].len, tbl[i].tgt,
                  tbl[i].st, tbl[i].ab, tbl[i].iv, tbl[i].b);
            tick("tbl");
            check($sformatf("tbl%0d.match", i),     32'(match),     32'(tbl[i].em));
            check($sformatf("tbl%0d.match_cnt", i), 32'(match_cnt), 32'(tbl[i].ecnt));
            check($sformatf("tbl%0d.busy", i),      32'(busy),      32'(tbl[i].eb));
            check($sformatf("tbl%0d.done", i),      32'(done),      32'(tbl[i].ed));
            check($sformatf("tbl%0d.cfg_ready", i), 32'(cfg_ready), 32'(tbl[i].er));
        end

        // overlap: 10101 over 1,0,1,0,1,0,1
        ov_bits = 7'b1010101;
        drive(1, 5'b10101, 3'd5, 8'd0, 0, 0, 0, 0); tick("ov_cfg");
        drive(0, '0, '0, '0, 1, 0, 0, 0);           tick("ov_start");
        pulses = 0; first_hit = -1;
        for (int i = 6; i >= 0; i--) begin
            send_bit(ov_bits[i], "ov");
            if (match) begin
                pulses++;
                if (first_hit < 0) first_hit = 7 - i;
            end
        end
        check("ov.first_hit_bit", 32'(first_hit), 32'd5);
`ifdef SEQ_DET_NOOVERLAP_EN
        check("ov.pulses", 32'(pulses), 32'd1);
        check("ov.cnt",    32'(match_cnt), 32'd1);
`else
        check("ov.pulses", 32'(pulses), 32'd2);
        check("ov.cnt",    32'(match_cnt), 32'd2);
`endif

        // same stream with in_valid gaps
        drive(0, '0, '0, '0, 0, 1, 0, 0);           tick("gap_abort");
        drive(1, 5'b10101, 3'd5, 8'd0, 0, 0, 0, 0); tick("gap_cfg");
        drive(0, '0, '0, '0, 1, 0, 0, 0);           tick("gap_start");
        gap_pulses = 0;
        begin
            int vp;
            vp = 0;
            for (int i = 6; i >= 0; i--) begin
                send_bit(ov_bits[i], "gap");
                if (match) vp++;
                for (int g = 0; g < 1 + (i % 2); g++) begin
                    drive(0, '0, '0, '0, 0, 0, 0, 1'(g));
                    tick("gap_idle");
                    if (match) gap_pulses++;
                end
            end
            check("gap.pulses", 32'(vp), 32'(pulses));
        end
        check("gap.no_pulse_on_gap", 32'(gap_pulses), 32'd0);

        // target stop: 11, target 3, stream 1,1,1,1,0,1,1
        ts_bits = 7'b1111011;
        drive(0, '0, '0, '0, 0, 1, 0, 0);           tick("ts_abort");
        drive(1, 5'b00011, 3'd2, 8'd3, 0, 0, 0, 0); tick("ts_cfg");
        drive(0, '0, '0, '0, 1, 0, 0, 0);           tick("ts_start");
        for (int i = 6; i >= 0; i--) begin
            send_bit(ts_bits[i], "ts");
`ifndef SEQ_DET_NOOVERLAP_EN
            if (i == 3) begin
                check("ts.bit4.match", 32'(match),     32'd1);
                check("ts.bit4.done",  32'(done),      32'd1);
                check("ts.bit4.busy",  32'(busy),      32'd0);
                check("ts.bit4.cnt",   32'(match_cnt), 32'd3);
            end
`endif
        end
        check("ts.final_cnt",  32'(match_cnt), 32'd3);
        check("ts.final_done", 32'(done),      32'd1);
        check("ts.final_match",32'(match),     32'd0);

        // simultaneous start and cfg in DONE: cfg wins, start dropped
        drive(1, 5'b00011, 3'd2, 8'd0, 1, 0, 0, 0); tick("sim_cfg_start");
        check("sim.busy",      32'(busy),      32'd0);
        check("sim.cfg_ready", 32'(cfg_ready), 32'd1);
        check("sim.done",      32'(done),      32'd0);
        drive(0, '0, '0, '0, 1, 0, 0, 0);           tick("ar_start");
        check("ar.cnt_cleared", 32'(match_cnt), 32'd0);
        send_bit(1, "ar"); send_bit(1, "ar");
        check("ar.cnt1", 32'(match_cnt), 32'd1);

        // abort and restart
        drive(0, '0, '0, '0, 1, 1, 1, 1);           tick("ab_abort");
        check("ab.busy",      32'(busy),      32'd0);
        check("ab.cfg_ready", 32'(cfg_ready), 32'd1);
        check("ab.cnt_held",  32'(match_cnt), 32'd1);
        drive(0, '0, '0, '0, 1, 0, 0, 0);           tick("ab_start_only");
        check("ab.start_ignored", 32'(busy), 32'd0);
        drive(1, 5'b00011, 3'd2, 8'd0, 0, 0, 0, 0); tick("ab_cfg");
        drive(0, '0, '0, '0, 1, 0, 0, 0);           tick("ab_restart");
        check("ab.restart_busy", 32'(busy),      32'd1);
        check("ab.restart_cnt",  32'(match_cnt), 32'd0);
        send_bit(1, "ab"); send_bit(1, "ab");

        // asynchronous reset in the middle of RUN
        #2 reset = 1'b1;
        #1;
        model_reset();
        check("rstrun.busy",      32'(busy),      32'd0);
        check("rstrun.match",     32'(match),     32'd0);
        check("rstrun.match_cnt", 32'(match_cnt), 32'd0);
        check("rstrun.done",      32'(done),      32'd0);
        check("rstrun.cfg_ready", 32'(cfg_ready), 32'd1);
        idle();
        @(posedge clk);
        #1 reset = 1'b0;

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 99) < 12,
                  PAT_W'($urandom),
                  LEN_W'($urandom_range(0, 7)),
                  CNT_W'($urandom_range(0, 5)),
                  $urandom_range(0, 99) < 12,
                  $urandom_range(0, 99) < 2,
                  $urandom_range(0, 99) < 75,
                  1'($urandom));
            tick("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
